// File: rtl/tx_scheduler.sv
// tx_scheduler: round-robin arbiter that holds the winner's code on tx_data for FRAME_LEN cycles, then idles GAP_LEN cycles.
// Optional macro TX_SCHED_PRIO_EN gives requester 0 fixed priority over the round-robin search.
module tx_scheduler #(
    parameter int FRAME_LEN = 6,
    parameter int GAP_LEN   = 2
) (
    input  logic       clk4,
    input  logic       reset4,
    input  logic [3:0] req,
    input  logic [2:0] code0,
    input  logic [2:0] code1,
    input  logic [2:0] code2,
    input  logic [2:0] code3,
    output logic [2:0] tx_data,
    output logic [3:0] grant,
    output logic       busy,
    output logic       done,
    output logic       err
);
    typedef enum logic [1:0] {IDLE, SEND, GAP} state_t;
    localparam int CW = $clog2((FRAME_LEN > GAP_LEN ? FRAME_LEN : GAP_LEN) + 1);
    localparam logic [CW-1:0] F_LAST = CW'(FRAME_LEN - 1);
    localparam logic [CW-1:0] G_LAST = CW'(GAP_LEN - 1);
    state_t        r_state;
    logic [CW-1:0] r_cnt;
    logic [1:0]    r_ptr;
    logic [1:0]    w_win;
    logic [2:0]    w_code;
    logic          w_valid;
    // Descending scan so the smallest offset from ptr+1 overwrites last and wins.
    always_comb begin
        w_win = r_ptr;
        for (int i = 4; i >= 1; i--)
            if (req[r_ptr + 2'(i)]) w_win = r_ptr + 2'(i);
`ifdef TX_SCHED_PRIO_EN
        if (req[0]) w_win = 2'd0;
`else
`endif
        w_code  = w_win == 2'd0 ? code0 : w_win == 2'd1 ? code1 : w_win == 2'd2 ? code2 : code3;
        w_valid = w_code != 3'b000 && w_code != 3'b111;
    end
    always_ff @(posedge clk4) begin
        if (reset4) begin
            r_state <= IDLE;
            r_cnt   <= '0;
            r_ptr   <= 2'd3;
            tx_data <= 3'b000;
            grant   <= 4'b0000;
            busy    <= 1'b0;
            done    <= 1'b0;
            err     <= 1'b0;
        end else begin
            done <= 1'b0;
            err  <= 1'b0;
            case (r_state)
                IDLE: if (|req) begin
                    r_ptr <= w_win;
                    if (w_valid) begin
                        r_state <= SEND;
                        grant   <= 4'b0001 << w_win;
                        tx_data <= w_code;
                        busy    <= 1'b1;
                        r_cnt   <= '0;
                    end else begin
                        err <= 1'b1;
                    end
                end
                SEND: if (r_cnt == F_LAST) begin
                    r_state <= GAP;
                    tx_data <= 3'b000;
                    grant   <= 4'b0000;
                    done    <= 1'b1;
                    r_cnt   <= '0;
                end else begin
                    r_cnt <= r_cnt + 1'b1;
                end
                GAP: if (r_cnt == G_LAST) begin
                    r_state <= IDLE;
                    busy    <= 1'b0;
                    r_cnt   <= '0;
                end else begin
                    r_cnt <= r_cnt + 1'b1;
                end
                default: r_state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_tx_scheduler.sv
// tb_tx_scheduler: table-driven, directed and random checks of tx_scheduler against a frame-window model.
module tb_tx_scheduler;
    localparam int F = 6;
    localparam int G = 2;
    logic       clk4 = 1'b0;
    logic       reset4;
    logic [3:0] req;
    logic [2:0] code0, code1, code2, code3;
    logic [2:0] tx_data;
    logic [3:0] grant;
    logic       busy, done, err;
    int n_chk = 0;
    int n_err = 0;
    // Model: a frame occupies a window of F+G cycles; m_left counts cycles still owed.
    int         m_left, m_ptr, m_owner;
    logic [2:0] m_code;
    logic       m_err;

    typedef struct {
        logic       rst;
        logic [3:0] q;
        logic [2:0] c0;
        logic [2:0] tx;
        logic [3:0] gnt;
        logic       bsy, dn, er;
    } vec_t;

    tx_scheduler #(.FRAME_LEN(F), .GAP_LEN(G)) dut (
        .clk4(clk4), .reset4(reset4), .req(req),
        .code0(code0), .code1(code1), .code2(code2), .code3(code3),
        .tx_data(tx_data), .grant(grant), .busy(busy), .done(done), .err(err)
    );

    always #5 clk4 = ~clk4;

    task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic model_step();
        logic [2:0] cs[4];
        int w;
        cs = '{code0, code1, code2, code3};
        if (reset4) begin
            m_left = 0; m_ptr = 3; m_owner = 0; m_code = 0; m_err = 0;
        end else begin
            m_err = 0;
            if (m_left > 0) m_left--;
            else if (req != 0) begin
                w = -1;
`ifdef TX_SCHED_PRIO_EN
                if (req[0]) w = 0;
`else
`endif
                for (int k = 1; k <= 4; k++)
                    if (w < 0 && req[(m_ptr + k) % 4]) w = (m_ptr + k) % 4;
                m_ptr = w;
                if (cs[w] != 3'd0 && cs[w] != 3'd7) begin
                    m_left = F + G; m_owner = w; m_code = cs[w];
                end else m_err = 1;
            end
        end
    endtask

    task automatic step(input logic r, input logic [3:0] q, input logic [2:0] a, b, c, d);
        logic snd;
        reset4 = r; req = q; code0 = a; code1 = b; code2 = c; code3 = d;
        model_step();
        @(negedge clk4);
        snd = m_left > G;
        chk("m_tx_data", 8'(tx_data), snd ? 8'(m_code) : 8'd0);
        chk("m_grant", 8'(grant), snd ? 8'(4'b0001 << m_owner) : 8'd0);
        chk("m_busy", 8'(busy), 8'(m_left > 0));
        chk("m_done", 8'(done), 8'(m_left == G));
        chk("m_err", 8'(err), 8'(m_err));
    endtask

    task automatic run(input int n, input logic [3:0] q, input logic [2:0] a, b, c, d);
        for (int i = 0; i < n; i++) step(1'b0, q, a, b, c, d);
    endtask

    initial begin
        vec_t tbl[11];
        tbl[0]  = '{1, 4'h0, 3'd0, 3'd0, 4'h0, 0, 0, 0};
        tbl[1]  = '{0, 4'h1, 3'd5, 3'd5, 4'h1, 1, 0, 0};
        for (int i = 2; i <= 6; i++) tbl[i] = '{0, 4'h0, 3'd5, 3'd5, 4'h1, 1, 0, 0};
        tbl[7]  = '{0, 4'h0, 3'd5, 3'd0, 4'h0, 1, 1, 0};
        tbl[8]  = '{0, 4'h0, 3'd5, 3'd0, 4'h0, 1, 0, 0};
        tbl[9]  = '{0, 4'h0, 3'd5, 3'd0, 4'h0, 0, 0, 0};
        tbl[10] = '{0, 4'h0, 3'd5, 3'd0, 4'h0, 0, 0, 0};
        for (int i = 0; i < 11; i++) begin
            step(tbl[i].rst, tbl[i].q, tbl[i].c0, 3'd1, 3'd1, 3'd1);
            chk("t_tx", 8'(tx_data), 8'(tbl[i].tx));
            chk("t_grant", 8'(grant), 8'(tbl[i].gnt));
            chk("t_busy", 8'(busy), 8'(tbl[i].bsy));
            chk("t_done", 8'(done), 8'(tbl[i].dn));
            chk("t_err", 8'(err), 8'(tbl[i].er));
        end
        // Fairness: order 0,1,2,3,0 with starts 9 cycles apart.
        step(1'b1, 4'h0, 3'd1, 3'd2, 3'd3, 3'd4);
        for (int f = 0; f < 5; f++) begin
            step(1'b0, 4'hF, 3'd1, 3'd2, 3'd3, 3'd4);
            chk("fair_grant", 8'(grant), 8'(4'b0001 << (f % 4)));
            chk("fair_tx", 8'(tx_data), 8'(f % 4 + 1));
            run(8, 4'hF, 3'd1, 3'd2, 3'd3, 3'd4);
        end
        // Invalid code then search resumes from ptr+1=3.
        step(1'b1, 4'h0, 3'd1, 3'd1, 3'd1, 3'd1);
        step(1'b0, 4'b0100, 3'd1, 3'd1, 3'd7, 3'd1);
        chk("inv_err", 8'(err), 8'd1);
        chk("inv_grant", 8'(grant), 8'd0);
        step(1'b0, 4'b0110, 3'd1, 3'd2, 3'd3, 3'd4);
        chk("inv_err_clr", 8'(err), 8'd0);
        chk("inv_next", 8'(grant), 8'b0010);
        step(1'b1, 4'h0, 3'd1, 3'd1, 3'd1, 3'd1);
        step(1'b0, 4'b0100, 3'd1, 3'd1, 3'd0, 3'd1);
        step(1'b0, 4'b1110, 3'd1, 3'd2, 3'd3, 3'd4);
        chk("inv_next3", 8'(grant), 8'b1000);
        // Mid-frame reset on the 3rd SEND cycle.
        step(1'b1, 4'h0, 3'd1, 3'd1, 3'd1, 3'd1);
        step(1'b0, 4'h1, 3'd5, 3'd1, 3'd1, 3'd1);
        run(2, 4'h0, 3'd5, 3'd1, 3'd1, 3'd1);
        step(1'b1, 4'h0, 3'd5, 3'd1, 3'd1, 3'd1);
        chk("rst_tx", 8'(tx_data), 8'd0);
        chk("rst_grant", 8'(grant), 8'd0);
        chk("rst_busy", 8'(busy), 8'd0);
        chk("rst_done", 8'(done), 8'd0);
        step(1'b0, 4'hF, 3'd1, 3'd2, 3'd3, 3'd4);
        chk("rst_first", 8'(grant), 8'b0001);
        // Code change during SEND is ignored.
        step(1'b1, 4'h0, 3'd1, 3'd1, 3'd1, 3'd1);
        step(1'b0, 4'h1, 3'd5, 3'd1, 3'd1, 3'd1);
        for (int i = 0; i < 5; i++) begin
            step(1'b0, 4'h1, 3'd2, 3'd1, 3'd1, 3'd1);
            chk("hold_tx", 8'(tx_data), 8'd5);
        end
        // Priority build: ptr=0, req=0011.
        step(1'b1, 4'h0, 3'd1, 3'd1, 3'd1, 3'd1);
        step(1'b0, 4'h1, 3'd5, 3'd6, 3'd1, 3'd1);
        run(8, 4'b0011, 3'd5, 3'd6, 3'd1, 3'd1);
        step(1'b0, 4'b0011, 3'd5, 3'd6, 3'd1, 3'd1);
`ifdef TX_SCHED_PRIO_EN
        chk("prio_grant", 8'(grant), 8'b0001);
`else
        chk("prio_grant", 8'(grant), 8'b0010);
`endif
        // Random traffic against the model.
        for (int i = 0; i < 600; i++)
            step(1'($urandom_range(49) == 0), 4'($urandom),
                 3'($urandom_range(7)), 3'($urandom_range(7)),
                 3'($urandom_range(7)), 3'($urandom_range(7)));
        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end
endmodule

// File: doc/tx_scheduler.md
TX_SCHEDULER -- requirements
Module: tx_scheduler

Interface
REQ-001 The block SHALL have parameter FRAME_LEN, default 6, meaning cycles each code is held on tx_data (3 bits x 2 clocks each in the serial transmitter).
REQ-002 The block SHALL have parameter GAP_LEN, default 2, meaning idle cycles with tx_data=000 between frames (valid range 1..15).
REQ-003 The block SHALL have a single clock and a synchronous, active-high reset, with ports as listed below.
REQ-004 The block SHALL have port clk4, input, 1 bit: the only clock; all state changes on its rising edge.
REQ-005 The block SHALL have port reset4, input, 1 bit: synchronous, active-high reset.
REQ-006 The block SHALL have port req, input, 4 bits: level request per requester 0..3.
REQ-007 The block SHALL have ports code0, code1, code2 and code3, each input, 3 bits: the code offered by each requester; only 001..110 are valid.
REQ-008 The block SHALL have port tx_data, output, 3 bits: drives the serial transmitter's datain input.
REQ-009 The block SHALL have port grant, output, 4 bits: one-hot owner of the transmitter, or 0000 when no requester owns it.
REQ-010 The block SHALL have port busy, output, 1 bit: high in SEND and GAP.
REQ-011 The block SHALL have port done, output, 1 bit: one-cycle pulse at frame end.
REQ-012 The block SHALL have port err, output, 1 bit: one-cycle pulse when an invalid code is rejected.

Function
REQ-013 The state machine SHALL have exactly the states IDLE, SEND and GAP, plus a 2-bit round-robin pointer ptr holding the last served requester.
REQ-014 In IDLE with req=0000, the block SHALL hold outputs at their reset values.
REQ-015 In IDLE with req!=0000, the winner w SHALL be the first set req bit searching ptr+1, ptr+2, ... modulo 4.
REQ-016 If code_w is valid, on the next edge the block SHALL: go to SEND; set grant=onehot(w); set tx_data=code_w (captured, so later changes to code_w are ignored); set busy=1; clear the counter; set ptr=w.
REQ-017 If code_w is 000 or 111, on the next edge the block SHALL: pulse err for one cycle; set ptr=w; stay in IDLE; leave grant at 0000.
REQ-018 In SEND, tx_data and grant SHALL stay constant for exactly FRAME_LEN cycles, and req changes SHALL be ignored.
REQ-019 At the end of the FRAME_LEN-th SEND cycle, the block SHALL go to GAP with tx_data=000 and grant=0000, and done SHALL be 1 during the first GAP cycle only.
REQ-020 The block SHALL stay in GAP for exactly GAP_LEN cycles with busy=1, then return to IDLE with busy=0.
REQ-021 Arbitration SHALL resume in the first IDLE cycle, so the minimum spacing between frame starts is FRAME_LEN+GAP_LEN+1 cycles.
REQ-022 A requester holding req after its done SHALL be served again only after every other active requester has had a turn.
REQ-023 The invalid-code check SHALL apply only at selection; a code that changes during SEND SHALL have no effect.

Reset
REQ-024 When reset4=1 at an edge, the block SHALL force state=IDLE, tx_data=000, grant=0000, busy=0, done=0, err=0, counter=0 and ptr=3, so requester 0 wins first.
REQ-025 A reset asserted during SEND or GAP SHALL abort the frame with no done pulse, and tx_data SHALL read 000 on the cycle after the reset edge.
REQ-026 Reset SHALL take priority over every other event on the same edge.

Configuration
REQ-027 With macro TX_SCHED_PRIO_EN defined, requester 0 SHALL win in IDLE whenever req[0]=1, regardless of ptr, and ptr SHALL still update to 0.
REQ-028 With TX_SCHED_PRIO_EN undefined, arbitration SHALL be pure round-robin per REQ-015, with no fixed priority.

Verification
REQ-029 Scenario, single frame: reset, then req=0001 and code0=101 -> one cycle later grant=0001 and tx_data=101 for 6 cycles, then done pulses once, tx_data=000 for 2 cycles, and busy falls.
REQ-030 Scenario, fairness: req=1111 held continuously with codes 001/010/011/100 -> frames go out in order 0,1,2,3,0, with starts 9 cycles apart.
REQ-031 Scenario, invalid code: req=0100 with code2=111 -> err pulses once, grant stays 0000, and a next request req=0110 with valid codes serves requester 3 if req[3] is set, otherwise requester 1 (search from ptr+1=3).
REQ-032 Scenario, mid-frame reset: reset4=1 on the 3rd SEND cycle -> the next cycle shows tx_data=000, grant=0000, busy=0 and no done pulse; the first request afterwards goes to requester 0.
REQ-033 Scenario, code change during SEND: code0 changes 101->010 mid-frame -> tx_data stays 101 for the whole frame.
REQ-034 Scenario, priority build: with TX_SCHED_PRIO_EN defined, ptr=0 and req=0011 -> requester 0 is granted again; without the macro, requester 1 is granted.
